uart_rx_param: RTL and testbench

Parametrised UART receiver. Line sampling uses an internal oversampling tick generator, so no external baud clock or start handshake is needed. Data width, parity mode, stop-bit count and oversampling ratio are configurable. Received words, with per-word error flags, are delivered over a valid/ready interface to the downstream consumer (command parser or FIFO).

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_rx_param.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encoding and the
// oversampling divider calculation.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE,
        WAIT_HIGH
    } uart_state_t;

    // Rounded clocks-per-tick, never below one.
    function automatic int uart_div(input int clk_hz, input int baud, input int os);
        longint den;
        longint q;
        den = longint'(baud) * longint'(os);
        q   = (longint'(clk_hz) + den / 2) / den;
        return (q < 1) ? 1 : int'(q);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle tick every DIV clocks, with a
// synchronous restart that realigns the phase to an external event.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    assign tick = (cnt_reg == LAST) && !restart;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with majority-vote sampling and a valid/ready
// output. Define UART_RX_BREAK_DET_EN to report all-zero frames on brk.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy,
    output logic                 brk
);

    localparam int DIV = uart_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int OSW = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);
    localparam int MID = OVERSAMPLE / 2;

    localparam logic [OSW-1:0] SAMP0   = OSW'(MID - 1);
    localparam logic [OSW-1:0] SAMP1   = OSW'(MID);
    localparam logic [OSW-1:0] DECIDE  = OSW'(MID + 1);
    localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_BITS - 1);

    uart_state_t state_reg, state_next;

    logic                 sync1_reg, rxs_reg, rxs_prev_reg;
    logic [OSW-1:0]       os_cnt_reg;
    logic [BW-1:0]        bit_cnt_reg;
    logic                 stop_cnt_reg;
    logic [1:0]           samp_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 perr_reg, ferr_reg;
    logic [DATA_BITS-1:0] rx_data_reg;
    logic                 rx_valid_reg, frame_err_reg, parity_err_reg;

    logic tick, start_edge, decide, bit_end, maj, par_exp;
    logic last_data, last_stop, is_break;
    logic load, ovr_pulse, brk_pulse;

    assign start_edge = (state_reg == IDLE) && rxs_prev_reg && !rxs_reg;
    assign decide     = tick && (os_cnt_reg == DECIDE);
    assign bit_end    = tick && (os_cnt_reg == OS_LAST);
    assign maj        = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rxs_reg) |
                        (samp_reg[1] & rxs_reg);
    assign par_exp    = (PARITY == PAR_ODD) ? ~(^shift_reg) : ^shift_reg;
    assign last_data  = (bit_cnt_reg == BIT_LAST);
    assign last_stop  = (STOP_BITS == 1) || stop_cnt_reg;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (start_edge),
        .tick    (tick)
    );

`ifdef UART_RX_BREAK_DET_EN
    // Cleared by any bit of the frame that votes high.
    logic zero_reg;
    always_ff @(posedge clk) begin
        if (rst || start_edge) begin
            zero_reg <= 1'b1;
        end else if (decide && maj) begin
            zero_reg <= 1'b0;
        end
    end
    assign is_break = zero_reg;
`else
    assign is_break = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        ovr_pulse  = 1'b0;
        brk_pulse  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_edge) state_next = START;
            end
            START: begin
                if (decide && maj) state_next = IDLE;
                else if (bit_end) state_next = DATA;
            end
            DATA: begin
                if (bit_end && last_data)
                    state_next = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
            end
            uart_pkg::PARITY: begin
                if (bit_end) state_next = STOP;
            end
            STOP: begin
                // Leave at the decision point so a new start bit can follow at once.
                if (decide && last_stop) state_next = DONE;
            end
            DONE: begin
                if (is_break) begin
                    brk_pulse  = 1'b1;
                    state_next = WAIT_HIGH;
                end else begin
                    if (!rx_valid_reg || rx_ready) load = 1'b1;
                    else ovr_pulse = 1'b1;
                    state_next = rxs_reg ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (rxs_reg) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg      <= 1'b1;
            rxs_reg        <= 1'b1;
            rxs_prev_reg   <= 1'b1;
            os_cnt_reg     <= '0;
            bit_cnt_reg    <= '0;
            stop_cnt_reg   <= 1'b0;
            samp_reg       <= '0;
            shift_reg      <= '0;
            perr_reg       <= 1'b0;
            ferr_reg       <= 1'b0;
            rx_data_reg    <= '0;
            rx_valid_reg   <= 1'b0;
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
        end else begin
            sync1_reg    <= rx_i;
            rxs_reg      <= sync1_reg;
            rxs_prev_reg <= rxs_reg;

            if (start_edge) begin
                os_cnt_reg   <= '0;
                bit_cnt_reg  <= '0;
                stop_cnt_reg <= 1'b0;
                perr_reg     <= 1'b0;
                ferr_reg     <= 1'b0;
            end else if (tick) begin
                os_cnt_reg <= (os_cnt_reg == OS_LAST) ? '0 : os_cnt_reg + OSW'(1);
            end

            if (tick && os_cnt_reg == SAMP0) samp_reg[0] <= rxs_reg;
            if (tick && os_cnt_reg == SAMP1) samp_reg[1] <= rxs_reg;

            if (decide) begin
                case (state_reg)
                    DATA:             shift_reg <= {maj, shift_reg[DATA_BITS-1:1]};
                    uart_pkg::PARITY: perr_reg  <= (maj != par_exp);
                    STOP:             if (!maj) ferr_reg <= 1'b1;
                    default: ;
                endcase
            end

            if (bit_end && state_reg == DATA)
                bit_cnt_reg <= last_data ? '0 : bit_cnt_reg + BW'(1);
            if (bit_end && state_reg == STOP)
                stop_cnt_reg <= ~stop_cnt_reg;

            if (load) begin
                rx_data_reg    <= shift_reg;
                frame_err_reg  <= ferr_reg;
                parity_err_reg <= perr_reg;
                rx_valid_reg   <= 1'b1;
            end else if (rx_valid_reg && rx_ready) begin
                rx_valid_reg <= 1'b0;
            end
        end
    end

    assign rx_data    = rx_data_reg;
    assign rx_valid   = rx_valid_reg;
    assign frame_err  = frame_err_reg;
    assign parity_err = parity_err_reg;
    assign overrun    = ovr_pulse;
    assign brk        = brk_pulse;
    assign busy       = (state_reg != IDLE) && (state_reg != WAIT_HIGH);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 instance and an 8E1 instance at 16 clk/bit,
// checked against a frame-level model queue plus hand-computed literals.
module tb_uart_rx_param;

    localparam int CLK_HZ   = 1600000;
    localparam int BAUD     = 100000;
    localparam int OS       = 16;
    localparam int BIT_CLKS = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } word_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, tx_line, sel_b, rx_a, rx_b, rdy_a, rdy_b;
    logic [7:0] data_a, data_b;
    logic val_a, ferr_a, perr_a, ovr_a, busy_a, brk_a;
    logic val_b, ferr_b, perr_b, ovr_b, busy_b, brk_b;

    assign rx_a = sel_b ? 1'b1 : tx_line;
    assign rx_b = sel_b ? tx_line : 1'b1;

    uart_rx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
                    .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .rx_i(rx_a), .rx_data(data_a), .rx_valid(val_a),
        .rx_ready(rdy_a), .frame_err(ferr_a), .parity_err(perr_a), .overrun(ovr_a),
        .busy(busy_a), .brk(brk_a));

    uart_rx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
                    .PARITY(2), .STOP_BITS(1)) dut_b (
        .clk(clk), .rst(rst), .rx_i(rx_b), .rx_data(data_b), .rx_valid(val_b),
        .rx_ready(rdy_b), .frame_err(ferr_b), .parity_err(perr_b), .overrun(ovr_b),
        .busy(busy_b), .brk(brk_b));

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    word_t exp_a[$];
    word_t exp_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    // Frame-level model: what a correct receiver reports for the bits sent.
    function automatic word_t frame_model(input logic [7:0] d, input logic has_par,
                                          input logic odd, input logic par_bit,
                                          input logic stop_bit);
        word_t w;
        w.data = d;
        w.ferr = !stop_bit;
        w.perr = has_par && (par_bit != ((^d) ^ odd));
        return w;
    endfunction

    // Observation state, written only by the compare process.
    logic       prev_a = 1'b0, prev_b = 1'b0;
    int         rise_cyc_a = 0, rises_a = 0, ovr_cnt_a = 0, brk_cnt_a = 0, busy_cnt_a = 0;
    int         ovr_cnt_b = 0;
    logic [7:0] last_data_a = 8'h00, last_data_b = 8'h00;
    logic       last_ferr_a = 1'b0, last_perr_b = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (val_a) begin
                if (exp_a.size() == 0) begin
                    check("a_unexpected_word", {24'd0, data_a}, 32'hFFFF_FFFF);
                end else begin
                    check("a_data", data_a, exp_a[0].data);
                    check("a_frame_err", ferr_a, exp_a[0].ferr);
                    check("a_parity_err", perr_a, exp_a[0].perr);
                    if (rdy_a) begin
                        last_data_a = data_a;
                        last_ferr_a = ferr_a;
                        void'(exp_a.pop_front());
                    end
                end
            end
            if (val_b) begin
                if (exp_b.size() == 0) begin
                    check("b_unexpected_word", {24'd0, data_b}, 32'hFFFF_FFFF);
                end else begin
                    check("b_data", data_b, exp_b[0].data);
                    check("b_frame_err", ferr_b, exp_b[0].ferr);
                    check("b_parity_err", perr_b, exp_b[0].perr);
                    if (rdy_b) begin
                        last_data_b = data_b;
                        last_perr_b = perr_b;
                        void'(exp_b.pop_front());
                    end
                end
            end
            if (val_a && !prev_a) begin
                rise_cyc_a = cyc;
                rises_a++;
            end
            if (ovr_a) ovr_cnt_a++;
            if (ovr_b) ovr_cnt_b++;
            if (brk_a) brk_cnt_a++;
            if (busy_a) busy_cnt_a++;
            prev_a = val_a;
            prev_b = val_b;
        end
    end

    int t_start = 0;

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // A 3-clk inversion over offsets 10..12 hits only the last vote sample.
    task automatic drive_bit(input logic b, input logic glitch);
        for (int i = 0; i < BIT_CLKS; i++) begin
            tx_line = (glitch && i >= 10 && i <= 12) ? ~b : b;
            tick_n(1);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic has_par, input logic par_bit,
                              input logic stop_bit, input int glitch_bit);
        t_start = cyc;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i], glitch_bit == i);
        if (has_par) drive_bit(par_bit, 1'b0);
        drive_bit(stop_bit, 1'b0);
    endtask

    task automatic idle(input int n);
        tx_line = 1'b1;
        tick_n(n);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_a.size() + exp_b.size()) != 0 && n < 400) begin
            tick_n(1);
            n++;
        end
        check(name, exp_a.size() + exp_b.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int snap0, snap1;
    int brk_expected;

    initial begin
        rst = 1'b1; tx_line = 1'b1; sel_b = 1'b0; rdy_a = 1'b1; rdy_b = 1'b1;
        tick_n(3);
        check("reset_a", {data_a, val_a, ferr_a, perr_a, ovr_a, busy_a, brk_a}, 0);
        check("reset_b", {data_b, val_b, ferr_b, perr_b, ovr_b, busy_b, brk_b}, 0);
        rst = 1'b0;
        idle(20);

        // 8N1 0xA5 with fixed latency and busy width
        snap0 = busy_cnt_a;
        exp_a.push_back(frame_model(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1));
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1);
        idle(20);
        wait_drain("t1_drain");
        check("t1_latency", rise_cyc_a - t_start, 158);
        check("t1_busy_cycles", busy_cnt_a - snap0, 155);
        check("t1_data_literal", last_data_a, 8'hA5);

        // 8E1: wrong parity, then right parity
        sel_b = 1'b1;
        idle(16);
        exp_b.push_back(frame_model(8'h07, 1'b1, 1'b0, 1'b0, 1'b1));
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, -1);
        idle(20);
        wait_drain("t2_drain_bad");
        check("t2_perr_literal", last_perr_b, 1'b1);
        check("t2_data_literal", last_data_b, 8'h07);
        exp_b.push_back(frame_model(8'h07, 1'b1, 1'b0, 1'b1, 1'b1));
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, -1);
        idle(20);
        wait_drain("t2_drain_good");
        check("t2_perr_clear_literal", last_perr_b, 1'b0);
        check("t2_b_overrun", ovr_cnt_b, 0);
        sel_b = 1'b0;
        idle(16);

        // Overrun: ready low, two frames back to back
        rdy_a = 1'b0;
        snap0 = ovr_cnt_a;
        exp_a.push_back(frame_model(8'h11, 1'b0, 1'b0, 1'b0, 1'b1));
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, -1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, -1);
        idle(10);
        check("t3_overrun_pulses", ovr_cnt_a - snap0, 1);
        check("t3_held_valid", val_a, 1'b1);
        check("t3_held_data", data_a, 8'h11);
        check("t3_queue_pending", exp_a.size(), 1);
        rdy_a = 1'b1;
        tick_n(1);
        check("t3_valid_fell", val_a, 1'b0);
        wait_drain("t3_drain");

        // 4-clk low glitch on idle line
        snap0 = rises_a;
        snap1 = busy_cnt_a;
        tx_line = 1'b0;
        tick_n(4);
        idle(20);
        check("t4_glitch_busy_cycles", busy_cnt_a - snap1, 10);
        check("t4_glitch_busy_low", busy_a, 1'b0);
        check("t4_glitch_no_word", rises_a - snap0, 0);

        // 3-clk glitch inside data bit 3
        exp_a.push_back(frame_model(8'h96, 1'b0, 1'b0, 1'b0, 1'b1));
        send_frame(8'h96, 1'b0, 1'b0, 1'b1, 3);
        idle(20);
        wait_drain("t4_drain");
        check("t4_vote_literal", last_data_a, 8'h96);

        // Bad stop bit followed by a held-low line
        snap0 = rises_a;
        exp_a.push_back(frame_model(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0));
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1);
        tick_n(3 * BIT_CLKS);
        check("t5_wait_high_busy", busy_a, 1'b0);
        idle(32);
        wait_drain("t5_drain");
        check("t5_ferr_literal", last_ferr_a, 1'b1);
        check("t5_single_word", rises_a - snap0, 1);

        // Reset during data bit 4 of 0xFF
        snap0 = rises_a;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
        tick_n(8);
        check("t6_busy_mid_frame", busy_a, 1'b1);
        rst = 1'b1;
        tick_n(2);
        check("t6_reset_outputs", {data_a, val_a, ferr_a, perr_a, ovr_a, busy_a, brk_a}, 0);
        rst = 1'b0;
        idle(40);
        check("t6_no_word", rises_a - snap0, 0);
        exp_a.push_back(frame_model(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1));
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, -1);
        idle(20);
        wait_drain("t6_drain");
        check("t6_data_literal", last_data_a, 8'h5A);

        // 12-bit-time break
        snap0 = brk_cnt_a;
`ifdef UART_RX_BREAK_DET_EN
        brk_expected = 1;
`else
        brk_expected = 0;
        exp_a.push_back(frame_model(8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
`endif
        tx_line = 1'b0;
        tick_n(12 * BIT_CLKS);
        check("t7_break_busy", busy_a, 1'b0);
        idle(32);
        wait_drain("t7_drain");
        check("t7_brk_pulses", brk_cnt_a - snap0, brk_expected);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
